pipe_mips_fwd: RTL and testbench

//  Single-clock, parametrised 5-stage (IF/ID/EX/MEM/WB) MIPS-style integer core; successor to the two-phase pipe core.

---
 rtl/pipe_mips_fwd.sv | 253 +++++++++++++++++++++++++
 tb/tb_pipe_mips_fwd.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mips_fwd.sv
// Five-stage MIPS-style integer core (IF/ID/EX/MEM/WB) with EX forwarding,
// load-use interlock, EX-resolved branches with flush, and halt/illegal status.
module pipe_mips_fwd #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int RESET_PC   = 0,
  parameter int FORWARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       retired
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;
  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  function automatic logic hits(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt,
                                input logic use_rs, input logic use_rt);
    return (d != 5'd0) && ((use_rs && (rs == d)) || (use_rt && (rt == d)));
  endfunction

  logic [DATA_W-1:0] regs [32];
  logic              halted_r, illegal_r;
  logic [31:0]       retired_r;

  logic [ADDR_W-1:0] pc_r, ifid_npc_r;
  logic              ifid_valid_r;
  logic [31:0]       ifid_ir_r;

  logic              idex_valid_r, idex_lw_r, idex_sw_r, idex_halt_r, idex_ill_r;
  logic [5:0]        idex_op_r;
  logic [4:0]        idex_rs_r, idex_rt_r, idex_dest_r;
  logic [DATA_W-1:0] idex_a_r, idex_b_r, idex_imm_r;
  logic [ADDR_W-1:0] idex_npc_r;

  logic              exmem_valid_r, exmem_lw_r, exmem_sw_r, exmem_halt_r, exmem_ill_r;
  logic [4:0]        exmem_dest_r;
  logic [DATA_W-1:0] exmem_alu_r, exmem_b_r;

  logic              memwb_valid_r, memwb_halt_r, memwb_ill_r;
  logic [4:0]        memwb_dest_r;
  logic [DATA_W-1:0] memwb_data_r;

  logic [5:0]        id_op;
  logic [4:0]        id_rs, id_rt, id_rd, id_dest;
  logic              id_rr, id_ri, id_lw, id_sw, id_br, id_hlt, id_ill, id_use_rs, id_use_rt;
  logic [DATA_W-1:0] id_a, id_b, id_imm;
  logic              wb_we, id_stall, halt_pending;
  logic [DATA_W-1:0] ex_a, ex_b, ex_alu;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;

  assign id_op  = ifid_ir_r[31:26];
  assign id_rs  = ifid_ir_r[25:21];
  assign id_rt  = ifid_ir_r[20:16];
  assign id_rd  = ifid_ir_r[15:11];
  assign id_imm = DATA_W'($signed(ifid_ir_r[15:0]));
  assign wb_we  = memwb_valid_r && (memwb_dest_r != 5'd0) && !halted_r;

  // Instruction decode plus write-first register read.
  always_comb begin
    id_rr = 1'b0; id_ri = 1'b0; id_lw = 1'b0; id_sw = 1'b0;
    id_br = 1'b0; id_hlt = 1'b0; id_ill = 1'b0;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_rr = 1'b1;
      OP_ADDI, OP_SUBI, OP_SLTI:                    id_ri = 1'b1;
      OP_LW:                                        id_lw = 1'b1;
      OP_SW:                                        id_sw = 1'b1;
      OP_BEQZ, OP_BNEQZ:                            id_br = 1'b1;
      OP_HLT:                                       id_hlt = 1'b1;
      default:                                      id_ill = 1'b1;
    endcase
    id_use_rs = id_rr | id_ri | id_lw | id_sw | id_br;
    id_use_rt = id_rr | id_sw;
    if (id_rr) id_dest = id_rd;
    else if (id_ri || id_lw) id_dest = id_rt;
    else id_dest = 5'd0;
    if (id_rs == 5'd0) id_a = '0;
    else if (wb_we && (memwb_dest_r == id_rs)) id_a = memwb_data_r;
    else id_a = regs[id_rs];
    if (id_rt == 5'd0) id_b = '0;
    else if (wb_we && (memwb_dest_r == id_rt)) id_b = memwb_data_r;
    else id_b = regs[id_rt];
  end

  // Hazard detection and fetch-stop when a halting op is anywhere in flight.
  always_comb begin
    if (FORWARD_EN != 0) begin
      id_stall = ifid_valid_r && idex_valid_r && idex_lw_r &&
                 hits(idex_dest_r, id_rs, id_rt, id_use_rs, id_use_rt);
    end else begin
      id_stall = ifid_valid_r &&
                 ((idex_valid_r && hits(idex_dest_r, id_rs, id_rt, id_use_rs, id_use_rt)) ||
                  (exmem_valid_r && hits(exmem_dest_r, id_rs, id_rt, id_use_rs, id_use_rt)));
    end
    halt_pending = (ifid_valid_r && (id_hlt || id_ill)) || (idex_valid_r && idex_halt_r) ||
                   (exmem_valid_r && exmem_halt_r) || (memwb_valid_r && memwb_halt_r);
  end

  // EX operand selection (newest producer wins), ALU and branch resolution.
  always_comb begin
    ex_a = idex_a_r;
    ex_b = idex_b_r;
    if (FORWARD_EN != 0) begin
      if (exmem_valid_r && (exmem_dest_r != 5'd0) && (exmem_dest_r == idex_rs_r)) ex_a = exmem_alu_r;
      else if (memwb_valid_r && (memwb_dest_r != 5'd0) && (memwb_dest_r == idex_rs_r)) ex_a = memwb_data_r;
      else ex_a = idex_a_r;
      if (exmem_valid_r && (exmem_dest_r != 5'd0) && (exmem_dest_r == idex_rt_r)) ex_b = exmem_alu_r;
      else if (memwb_valid_r && (memwb_dest_r != 5'd0) && (memwb_dest_r == idex_rt_r)) ex_b = memwb_data_r;
      else ex_b = idex_b_r;
    end else begin
      ex_a = idex_a_r;
      ex_b = idex_b_r;
    end
    case (idex_op_r)
      OP_ADD:         ex_alu = ex_a + ex_b;
      OP_SUB:         ex_alu = ex_a - ex_b;
      OP_AND:         ex_alu = ex_a & ex_b;
      OP_OR:          ex_alu = ex_a | ex_b;
      OP_SLT:         ex_alu = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      OP_MUL:         ex_alu = ex_a * ex_b;
      OP_ADDI, OP_LW,
      OP_SW:          ex_alu = ex_a + idex_imm_r;
      OP_SUBI:        ex_alu = ex_a - idex_imm_r;
      OP_SLTI:        ex_alu = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(idex_imm_r))};
      default:        ex_alu = '0;
    endcase
    ex_taken  = idex_valid_r && (((idex_op_r == OP_BEQZ) && (ex_a == '0)) ||
                                 ((idex_op_r == OP_BNEQZ) && (ex_a != '0)));
    ex_target = idex_npc_r + idex_imm_r[ADDR_W-1:0];
  end

  // PC and IF/ID: taken branch beats stall, stall beats fetch-stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= RESET_PC_A;
      ifid_valid_r <= 1'b0;
      ifid_ir_r    <= 32'd0;
      ifid_npc_r   <= '0;
    end else if (!halted_r) begin
      if (ex_taken) begin
        pc_r         <= ex_target;
        ifid_valid_r <= 1'b0;
      end else if (id_stall) begin
        pc_r         <= pc_r;
      end else if (halt_pending) begin
        ifid_valid_r <= 1'b0;
      end else begin
        pc_r         <= pc_r + ADDR_W'(1);
        ifid_valid_r <= 1'b1;
        ifid_ir_r    <= imem_rdata;
        ifid_npc_r   <= pc_r + ADDR_W'(1);
      end
    end
  end

  // ID/EX register; a stall or flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid_r <= 1'b0;
      idex_lw_r <= 1'b0; idex_sw_r <= 1'b0; idex_halt_r <= 1'b0; idex_ill_r <= 1'b0;
      idex_op_r <= 6'd0; idex_rs_r <= 5'd0; idex_rt_r <= 5'd0; idex_dest_r <= 5'd0;
      idex_a_r <= '0; idex_b_r <= '0; idex_imm_r <= '0; idex_npc_r <= '0;
    end else if (!halted_r) begin
      idex_valid_r <= ifid_valid_r && !ex_taken && !id_stall;
      idex_lw_r    <= id_lw;
      idex_sw_r    <= id_sw;
      idex_halt_r  <= id_hlt | id_ill;
      idex_ill_r   <= id_ill;
      idex_op_r    <= id_op;
      idex_rs_r    <= id_rs;
      idex_rt_r    <= id_rt;
      idex_dest_r  <= id_dest;
      idex_a_r     <= id_a;
      idex_b_r     <= id_b;
      idex_imm_r   <= id_imm;
      idex_npc_r   <= ifid_npc_r;
    end
  end

  // EX/MEM and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_valid_r <= 1'b0;
      exmem_lw_r <= 1'b0; exmem_sw_r <= 1'b0; exmem_halt_r <= 1'b0; exmem_ill_r <= 1'b0;
      exmem_dest_r <= 5'd0; exmem_alu_r <= '0; exmem_b_r <= '0;
      memwb_valid_r <= 1'b0; memwb_halt_r <= 1'b0; memwb_ill_r <= 1'b0;
      memwb_dest_r <= 5'd0; memwb_data_r <= '0;
    end else if (!halted_r) begin
      exmem_valid_r <= idex_valid_r;
      exmem_lw_r    <= idex_lw_r;
      exmem_sw_r    <= idex_sw_r;
      exmem_halt_r  <= idex_halt_r;
      exmem_ill_r   <= idex_ill_r;
      exmem_dest_r  <= idex_dest_r;
      exmem_alu_r   <= ex_alu;
      exmem_b_r     <= ex_b;
      memwb_valid_r <= exmem_valid_r;
      memwb_halt_r  <= exmem_halt_r;
      memwb_ill_r   <= exmem_ill_r;
      memwb_dest_r  <= exmem_dest_r;
      memwb_data_r  <= exmem_lw_r ? dmem_rdata : exmem_alu_r;
    end
  end

  // Write-back: register file, retire counter and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
      retired_r <= 32'd0;
    end else if (!halted_r && memwb_valid_r) begin
      if (memwb_dest_r != 5'd0) regs[memwb_dest_r] <= memwb_data_r;
      retired_r <= retired_r + 32'd1;
      if (memwb_halt_r) halted_r <= 1'b1;
      if (memwb_ill_r) illegal_r <= 1'b1;
    end
  end

  assign imem_addr  = pc_r;
  assign dmem_addr  = exmem_alu_r[ADDR_W-1:0];
  assign dmem_wdata = exmem_b_r;
  assign dmem_we    = exmem_valid_r && exmem_sw_r && !halted_r;
  assign dbg_rdata  = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];
  assign halted     = halted_r;
  assign illegal    = illegal_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_pipe_mips_fwd.sv
// Directed programs run on a forwarding core and an interlock-only core;
// register/status expectations come from hand-computed tables.
module tb_pipe_mips_fwd;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  ia1, ia0, da1, da0;
  logic [31:0] id1, id0, dw1, dw0, dr1, dr0, dbg1, dbg0, ret1, ret0;
  logic        we1, we0, h1, h0, il1, il0;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] imem [0:1023];
  logic [31:0] dmem1 [0:1023];
  logic [31:0] dmem0 [0:1023];

  assign id1 = imem[ia1];
  assign id0 = imem[ia0];
  assign dr1 = dmem1[da1];
  assign dr0 = dmem0[da0];

  pipe_mips_fwd #(.FORWARD_EN(1)) dut (
    .clk(clk), .rst(rst), .imem_addr(ia1), .imem_rdata(id1), .dmem_addr(da1), .dmem_wdata(dw1),
    .dmem_we(we1), .dmem_rdata(dr1), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg1), .halted(h1),
    .illegal(il1), .retired(ret1));

  pipe_mips_fwd #(.FORWARD_EN(0)) dut_nf (
    .clk(clk), .rst(rst), .imem_addr(ia0), .imem_rdata(id0), .dmem_addr(da0), .dmem_wdata(dw0),
    .dmem_we(we0), .dmem_rdata(dr0), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg0), .halted(h0),
    .illegal(il0), .retired(ret0));

  typedef struct { int prog; logic [4:0] idx; logic [31:0] exp; } vec_t;
  typedef struct { logic [31:0] ret; logic ill; int cyc1; int cyc0; } prog_t;
  vec_t  vecs [25];
  prog_t progs [8];

  int errors = 0;
  int checks = 0;
  int c1, c0, wecnt;
  logic [31:0] prev_ret, ret_before, we_addr, we_data, snap_ret;
  logic [9:0]  snap_pc;

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction
  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int p);
    for (int k = 0; k < 1024; k++) begin
      imem[k] = 32'd0; dmem1[k] = 32'd0; dmem0[k] = 32'd0;
    end
    case (p)
      1: begin
        imem[0] = ri(ADDI, 5'd1, 5'd0, 16'd5); imem[1] = ri(ADDI, 5'd2, 5'd0, 16'd7);
        imem[2] = rr(ADD, 5'd3, 5'd1, 5'd2);   imem[3] = {HLT, 26'd0};
      end
      2: begin
        dmem1[0] = 32'd9; dmem0[0] = 32'd9;
        imem[0] = ri(LW, 5'd4, 5'd0, 16'd0); imem[1] = rr(ADD, 5'd5, 5'd4, 5'd4);
        imem[2] = {HLT, 26'd0};
      end
      3: begin
        imem[0] = ri(BEQZ, 5'd0, 5'd0, 16'd2); imem[1] = ri(ADDI, 5'd6, 5'd0, 16'd1);
        imem[2] = ri(ADDI, 5'd6, 5'd0, 16'd1); imem[3] = ri(ADDI, 5'd7, 5'd0, 16'd3);
        imem[4] = {HLT, 26'd0};
      end
      4: begin
        imem[0] = ri(ADDI, 5'd2, 5'd0, 16'd7); imem[1] = ri(SW, 5'd2, 5'd0, 16'd3);
        imem[2] = ri(LW, 5'd8, 5'd0, 16'd3);   imem[3] = {HLT, 26'd0};
      end
      5: begin
        imem[0]  = ri(ADDI, 5'd10, 5'd0, 16'hFFFF); imem[1]  = ri(SLTI, 5'd9, 5'd10, 16'd1);
        imem[2]  = ri(ADDI, 5'd11, 5'd0, 16'd256);  imem[3]  = rr(MUL, 5'd12, 5'd11, 5'd11);
        imem[4]  = rr(MUL, 5'd13, 5'd12, 5'd12);    imem[5]  = rr(SUB, 5'd14, 5'd0, 5'd11);
        imem[6]  = rr(AND_, 5'd15, 5'd14, 5'd10);   imem[7]  = rr(OR_, 5'd16, 5'd11, 5'd9);
        imem[8]  = rr(SLT, 5'd17, 5'd14, 5'd0);     imem[9]  = ri(SUBI, 5'd18, 5'd11, 16'd1);
        imem[10] = ri(BNEQZ, 5'd0, 5'd9, 16'd1);    imem[11] = ri(ADDI, 5'd19, 5'd0, 16'd9);
        imem[12] = ri(ADDI, 5'd20, 5'd0, 16'd4);    imem[13] = {HLT, 26'd0};
      end
      6: begin
        imem[0] = {HLT, 26'd0};                 imem[1] = ri(ADDI, 5'd21, 5'd0, 16'd1);
        imem[2] = ri(ADDI, 5'd22, 5'd0, 16'd1); imem[3] = ri(ADDI, 5'd23, 5'd0, 16'd1);
      end
      default: begin
        imem[0] = ri(ADDI, 5'd1, 5'd0, 16'd3); imem[1] = 32'h4000_0000;
        imem[2] = ri(ADDI, 5'd2, 5'd0, 16'd4);
      end
    endcase
  endtask

  // Runs until both cores halt; memory stores are applied here from the observed strobes.
  task automatic run();
    c1 = -1; c0 = -1; wecnt = 0; ret_before = 32'd0; we_addr = 32'd0; we_data = 32'd0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      prev_ret = ret1;
      @(posedge clk); #1;
      if (h1 && c1 < 0) begin c1 = cyc; ret_before = prev_ret; end
      if (h0 && c0 < 0) c0 = cyc;
      if (we1) begin wecnt++; we_addr = {22'd0, da1}; we_data = dw1; dmem1[da1] = dw1; end
      if (we0) dmem0[da0] = dw0;
      if (c1 >= 0 && c0 >= 0) break;
    end
    chk("halted_fwd", {31'd0, h1}, 32'd1);
    chk("halted_nofwd", {31'd0, h0}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1, 5'd1, 32'd5};        vecs[1]  = '{1, 5'd2, 32'd7};
    vecs[2]  = '{1, 5'd3, 32'd12};       vecs[3]  = '{2, 5'd4, 32'd9};
    vecs[4]  = '{2, 5'd5, 32'd18};       vecs[5]  = '{3, 5'd6, 32'd0};
    vecs[6]  = '{3, 5'd7, 32'd3};        vecs[7]  = '{4, 5'd2, 32'd7};
    vecs[8]  = '{4, 5'd8, 32'd7};        vecs[9]  = '{5, 5'd9, 32'd1};
    vecs[10] = '{5, 5'd10, 32'hFFFF_FFFF}; vecs[11] = '{5, 5'd11, 32'd256};
    vecs[12] = '{5, 5'd12, 32'h0001_0000}; vecs[13] = '{5, 5'd13, 32'd0};
    vecs[14] = '{5, 5'd14, 32'hFFFF_FF00}; vecs[15] = '{5, 5'd15, 32'hFFFF_FF00};
    vecs[16] = '{5, 5'd16, 32'd257};     vecs[17] = '{5, 5'd17, 32'd1};
    vecs[18] = '{5, 5'd18, 32'd255};     vecs[19] = '{5, 5'd19, 32'd0};
    vecs[20] = '{5, 5'd20, 32'd4};       vecs[21] = '{6, 5'd21, 32'd0};
    vecs[22] = '{6, 5'd23, 32'd0};       vecs[23] = '{7, 5'd1, 32'd3};
    vecs[24] = '{7, 5'd2, 32'd0};
    progs[0] = '{32'd0, 1'b0, -1, -1};
    progs[1] = '{32'd4, 1'b0, 8, 10};
    progs[2] = '{32'd3, 1'b0, 8, 9};
    progs[3] = '{32'd3, 1'b0, -1, -1};
    progs[4] = '{32'd4, 1'b0, -1, -1};
    progs[5] = '{32'd13, 1'b0, -1, -1};
    progs[6] = '{32'd1, 1'b0, -1, -1};
    progs[7] = '{32'd2, 1'b1, -1, -1};

    for (int p = 1; p <= 7; p++) begin
      rst = 1'b1;
      load(p);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("p%0d_rst_retired", p), ret1, 32'd0);
      chk($sformatf("p%0d_rst_halted", p), {31'd0, h1}, 32'd0);
      chk($sformatf("p%0d_rst_illegal", p), {31'd0, il0}, 32'd0);
      chk($sformatf("p%0d_rst_pc", p), {22'd0, ia1}, 32'd0);
      rst = 1'b0;
      run();
      for (int i = 0; i < 25; i++) begin
        if (vecs[i].prog == p) begin
          dbg_raddr = vecs[i].idx;
          @(negedge clk);
          chk($sformatf("p%0d_fwd_r%0d", p, vecs[i].idx), dbg1, vecs[i].exp);
          chk($sformatf("p%0d_nofwd_r%0d", p, vecs[i].idx), dbg0, vecs[i].exp);
        end
      end
      chk($sformatf("p%0d_retired_fwd", p), ret1, progs[p].ret);
      chk($sformatf("p%0d_retired_nofwd", p), ret0, progs[p].ret);
      chk($sformatf("p%0d_illegal_fwd", p), {31'd0, il1}, {31'd0, progs[p].ill});
      chk($sformatf("p%0d_illegal_nofwd", p), {31'd0, il0}, {31'd0, progs[p].ill});
      if (progs[p].cyc1 >= 0) begin
        chk($sformatf("p%0d_cycles_fwd", p), c1, progs[p].cyc1);
        chk($sformatf("p%0d_cycles_nofwd", p), c0, progs[p].cyc0);
      end
      if (p == 1) chk("p1_retired_before_hlt", ret_before, 32'd3);
      if (p == 4) begin
        chk("p4_we_count", wecnt, 32'd1);
        chk("p4_we_addr", we_addr, 32'd3);
        chk("p4_we_data", we_data, 32'd7);
      end
      if (p == 6) begin
        snap_ret = ret1; snap_pc = ia1;
        repeat (5) @(posedge clk);
        #1;
        chk("p6_frozen_retired", ret1, snap_ret);
        chk("p6_frozen_pc", {22'd0, ia1}, {22'd0, snap_pc});
        chk("p6_frozen_we", {31'd0, we1}, 32'd0);
      end
    end

    // Reset in the middle of a program.
    rst = 1'b1;
    load(5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    dbg_raddr = 5'd10;
    #1;
    chk("mid_r10_before_rst", dbg1, 32'hFFFF_FFFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_halted", {31'd0, h1}, 32'd0);
    chk("mid_rst_illegal", {31'd0, il1}, 32'd0);
    chk("mid_rst_retired", ret1, 32'd0);
    chk("mid_rst_pc", {22'd0, ia1}, 32'd0);
    chk("mid_rst_we", {31'd0, we1}, 32'd0);
    chk("mid_rst_r10", dbg1, 32'd0);
    chk("mid_rst_retired_nofwd", ret0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
